// File: rtl/lb_pkg.sv
// Shared line-buffer types for the draw-domain controller: pixel/word widths,
// colour and word types, and the scheduler state encoding.
package lb_pkg;

  localparam int WORD_PX     = 8;
  localparam int COLOUR_W    = 9;
  localparam int WORD_ADDR_W = 9;
  localparam int WORD_W      = WORD_PX * COLOUR_W;

  typedef logic [COLOUR_W-1:0] colour_t;
  typedef logic [WORD_W-1:0]   word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } lfs_state_e;

  function automatic word_t replicate_colour(input colour_t c);
    return {WORD_PX{c}};
  endfunction

endpackage

// File: rtl/line_flip_sched_if.sv
// Engine write-request channel into the off-screen line buffer (valid/ready).
interface line_flip_sched_if;
  import lb_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [WORD_ADDR_W-1:0] req_addr;
  logic [WORD_PX-1:0]     req_we;
  word_t                  req_colour;
  logic                   req_last;

  modport master (
    output req_valid, req_addr, req_we, req_colour, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_colour, req_last,
    output req_ready
  );

endinterface

// File: rtl/line_flip_sched_toggle_sync.sv
// Brings the pixel-domain line toggle into the draw clock and turns each
// change of level (either polarity) into a single-cycle flip_evt_o.
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic toggle_i,
  output logic flip_evt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   flip_q;

  // NOTE: non-blocking assignments keep every stage sampling the pre-edge value,
  // so the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      flip_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      flip_q <= sync_q[SYNC_STAGES-1] ^ prev_q;
    end
  end

  assign flip_evt_o = flip_q;

endmodule

// File: rtl/line_flip_sched.sv
// Draw-domain line flip scheduler: owns buffsel_draw, sweeps the clear colour over
// the on-screen buffer and grants the off-screen port. Optional `LFS_STATS_EN counters.
module line_flip_sched
  import lb_pkg::*;
#(
  parameter int CLEAR_WORDS = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_draw,
  input  logic                   rst_draw_n,
  input  logic                   line_toggle_pix,
  input  colour_t                clear_colour,
  line_flip_sched_if.slave       req,
  output logic                   line_start,
  output logic                   buffsel_draw,
  output logic [WORD_ADDR_W-1:0] addr_on_draw,
  output logic                   we_on_draw,
  output word_t                  colour_on_draw,
  output logic [WORD_ADDR_W-1:0] addr_off_draw,
  output logic [WORD_PX-1:0]     we_off_draw,
  output word_t                  colour_off_draw,
  output logic [1:0]             overrun,
  output logic [15:0]            ovr_draw_cnt,
  output logic [15:0]            ovr_clear_cnt
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_DRAW = 2'(DRAW);
  localparam logic [1:0] ST_DONE = 2'(DONE);
  localparam logic [WORD_ADDR_W-1:0] LAST_ADDR = WORD_ADDR_W'(CLEAR_WORDS - 1);

  logic                   flip_evt;
  logic [1:0]             state_q, state_d;
  logic                   buffsel_q, line_start_q;
  logic [WORD_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic                   clr_act_q, clr_act_d;
  colour_t                clr_colour_q;
  logic [WORD_ADDR_W-1:0] addr_off_q;
  logic [WORD_PX-1:0]     we_off_q;
  word_t                  colour_off_q;
  logic                   xfer;

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk_draw),
    .rst_n      (rst_draw_n),
    .toggle_i   (line_toggle_pix),
    .flip_evt_o (flip_evt)
  );

  // Blocking the flip cycle keeps every accepted write in the pre-flip off-screen buffer.
  assign req.req_ready = (state_q == ST_DRAW) && !flip_evt;
  assign xfer          = req.req_valid && req.req_ready;

  always_comb begin
    // NOTE: defaulting every comb output first means no path leaves it unassigned (no latch).
    state_d = state_q;
    if (flip_evt)                                              state_d = ST_DRAW;
    else if (state_q == ST_DRAW && xfer && req.req_last)       state_d = ST_DONE;
  end

  always_comb begin
    clr_cnt_d = clr_cnt_q;
    clr_act_d = clr_act_q;
    if (flip_evt) begin
      clr_cnt_d = '0;
      clr_act_d = 1'b1;
    end else if (clr_act_q) begin
      if (clr_cnt_q == LAST_ADDR) clr_act_d = 1'b0;
      else                        clr_cnt_d = clr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      state_q      <= ST_IDLE;
      buffsel_q    <= 1'b0;
      line_start_q <= 1'b0;
      clr_cnt_q    <= '0;
      clr_act_q    <= 1'b0;
      clr_colour_q <= '0;
      addr_off_q   <= '0;
      we_off_q     <= '0;
      colour_off_q <= '0;
    end else begin
      state_q      <= state_d;
      buffsel_q    <= buffsel_q ^ flip_evt;
      line_start_q <= flip_evt;
      clr_cnt_q    <= clr_cnt_d;
      clr_act_q    <= clr_act_d;
      if (flip_evt) clr_colour_q <= clear_colour;
      addr_off_q   <= req.req_addr;
      we_off_q     <= xfer ? req.req_we : '0;
      colour_off_q <= req.req_colour;
    end
  end

  // A word issued in the flip cycle itself (count at LAST_ADDR) counts as cleared.
  assign overrun[0] = flip_evt && (state_q == ST_DRAW);
  assign overrun[1] = flip_evt && clr_act_q && (clr_cnt_q != LAST_ADDR);

  assign line_start      = line_start_q;
  assign buffsel_draw    = buffsel_q;
  assign addr_on_draw    = clr_cnt_q;
  assign we_on_draw      = clr_act_q;
  assign colour_on_draw  = replicate_colour(clr_colour_q);
  assign addr_off_draw   = addr_off_q;
  assign we_off_draw     = we_off_q;
  assign colour_off_draw = colour_off_q;

`ifdef LFS_STATS_EN
  logic [15:0] ovr_draw_q, ovr_clear_q;

  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      ovr_draw_q  <= '0;
      ovr_clear_q <= '0;
    end else begin
      if (overrun[0] && ovr_draw_q  != 16'hFFFF) ovr_draw_q  <= ovr_draw_q  + 16'd1;
      if (overrun[1] && ovr_clear_q != 16'hFFFF) ovr_clear_q <= ovr_clear_q + 16'd1;
    end
  end

  assign ovr_draw_cnt  = ovr_draw_q;
  assign ovr_clear_cnt = ovr_clear_q;
`else
  assign ovr_draw_cnt  = '0;
  assign ovr_clear_cnt = '0;
`endif

endmodule

// File: tb/tb_line_flip_sched.sv
// Randomised bench for line_flip_sched against a cycle-level behavioural model of
// flips, the clear sweep, the engine line and overrun accounting.
module tb_line_flip_sched;
  import lb_pkg::*;

  localparam int CW = 80;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tog;
  colour_t     clr_col;
  logic        line_start, buffsel_draw, we_on_draw;
  logic [8:0]  addr_on_draw, addr_off_draw;
  word_t       colour_on_draw, colour_off_draw;
  logic [7:0]  we_off_draw;
  logic [1:0]  overrun;
  logic [15:0] ovr_draw_cnt, ovr_clear_cnt;

  line_flip_sched_if req_if();

  line_flip_sched #(.CLEAR_WORDS(CW), .SYNC_STAGES(SS)) dut (
    .clk_draw        (clk),
    .rst_draw_n      (rst_n),
    .line_toggle_pix (tog),
    .clear_colour    (clr_col),
    .req             (req_if),
    .line_start      (line_start),
    .buffsel_draw    (buffsel_draw),
    .addr_on_draw    (addr_on_draw),
    .we_on_draw      (we_on_draw),
    .colour_on_draw  (colour_on_draw),
    .addr_off_draw   (addr_off_draw),
    .we_off_draw     (we_off_draw),
    .colour_off_draw (colour_off_draw),
    .overrun         (overrun),
    .ovr_draw_cnt    (ovr_draw_cnt),
    .ovr_clear_cnt   (ovr_clear_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: toggle samples seen by the draw clock (newest first), line/engine/clear status.
  bit      hist[$];
  bit      m_draw, m_bsel, m_ls, m_xfer, m_obuf;
  int      m_clr;            // word being cleared this cycle; CW means no sweep
  colour_t m_ccol;
  logic [7:0] m_owe;
  logic [8:0] m_oaddr;
  word_t   m_ocol;
  int      m_cd, m_cc;

  // Next-cycle stimulus chosen by the sequences below.
  bit         n_rst, n_tog, n_valid, n_last;
  colour_t    n_col;
  logic [8:0] n_addr;
  logic [7:0] n_we;
  word_t      n_wcol;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < SS + 2; i++) hist.push_back(1'b0);
    m_draw = 0; m_bsel = 0; m_ls = 0; m_xfer = 0; m_obuf = 0;
    m_clr = CW; m_ccol = '0;
    m_owe = '0; m_oaddr = '0; m_ocol = '0;
    m_cd = 0; m_cc = 0;
  endtask

  task automatic tick();
    bit         flip, rdy;
    logic [1:0] ov;
    @(negedge clk);
    // A level change is seen SS samples later and flagged one register after that.
    flip = hist[SS] ^ hist[SS+1];
    rdy  = m_draw && !flip;
    ov   = {flip && (m_clr < CW - 1), flip && m_draw};
    if (!rst_n) begin
      check("reset_ctrl", 80'({req_if.req_ready, line_start, buffsel_draw, addr_on_draw, we_on_draw,
                               addr_off_draw, we_off_draw, overrun, ovr_draw_cnt, ovr_clear_cnt}), 80'(0));
      check("reset_colour_on", 80'(colour_on_draw), 80'(0));
      check("reset_colour_off", 80'(colour_off_draw), 80'(0));
    end else begin
      check("ctrl{ready,ls,bsel,ovr,we_on}",
            80'({req_if.req_ready, line_start, buffsel_draw, overrun, we_on_draw}),
            80'({rdy, m_ls, m_bsel, ov, (m_clr < CW)}));
      if (m_clr < CW) begin
        check("clr_addr", 80'(addr_on_draw), 80'(m_clr));
        check("clr_colour", 80'(colour_on_draw), 80'({8{m_ccol}}));
      end
      check("off_we", 80'(we_off_draw), 80'(m_owe));
      if (m_owe != 0) begin
        check("off_addr", 80'(addr_off_draw), 80'(m_oaddr));
        check("off_colour", 80'(colour_off_draw), 80'(m_ocol));
        check("off_target_buf", 80'(buffsel_draw), 80'(!m_obuf));
      end
      check("stats", 80'({ovr_draw_cnt, ovr_clear_cnt}), 80'({m_cd[15:0], m_cc[15:0]}));
    end

    rst_n             = n_rst;
    tog               = n_tog;
    clr_col           = n_col;
    req_if.req_valid  = n_valid;
    req_if.req_addr   = n_addr;
    req_if.req_we     = n_we;
    req_if.req_colour = n_wcol;
    req_if.req_last   = n_last;

    if (!n_rst) begin
      model_reset();
    end else begin
      m_xfer = n_valid && rdy;
      m_owe  = m_xfer ? n_we : 8'h00;
      m_oaddr = n_addr;
      m_ocol = n_wcol;
      m_obuf = !m_bsel;
      m_ls   = flip;
      if (flip) begin
        m_bsel = !m_bsel;
        m_clr  = 0;
        m_ccol = n_col;
        m_draw = 1;
      end else begin
        if (m_clr < CW) m_clr++;
        if (m_xfer && n_last) m_draw = 0;
      end
`ifdef LFS_STATS_EN
      if (ov[0] && m_cd < 65535) m_cd++;
      if (ov[1] && m_cc < 65535) m_cc++;
`endif
      hist.push_front(n_tog);
      void'(hist.pop_back());
    end
  endtask

  task automatic gen_req(input int p_valid, input int p_last);
    if (n_valid && !m_xfer) return;  // hold the request until it is accepted
    n_valid = ($urandom_range(0, 99) < p_valid);
    n_addr  = 9'($urandom_range(0, 511));
    n_we    = 8'($urandom);
    n_wcol  = word_t'({$urandom(), $urandom(), $urandom()});
    n_last  = ($urandom_range(0, 99) < p_last);
  endtask

  int tcnt;

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (tcnt == 0) begin
        n_tog = !n_tog;
        n_col = 9'($urandom);
        case ($urandom_range(0, 3))
          0:       tcnt = 40;
          1:       tcnt = $urandom_range(20, 79);
          default: tcnt = $urandom_range(90, 220);
        endcase
      end else begin
        tcnt--;
      end
      gen_req(60, 3);
      tick();
    end
  endtask

  int run, run_max, waited;

  initial begin
    n_rst = 0; n_tog = 0; n_col = 9'h1A5; n_valid = 0; n_last = 0;
    n_addr = '0; n_we = '0; n_wcol = '0;
    rst_n = 0; tog = 0; clr_col = '0;
    req_if.req_valid = 0; req_if.req_addr = '0; req_if.req_we = '0;
    req_if.req_colour = '0; req_if.req_last = 0;
    model_reset();

    repeat (3) tick();
    n_rst = 1;
    repeat (2) tick();

    // Single flip with an idle engine: expect one clear sweep of CW consecutive words.
    n_tog = 1;
    run = 0; run_max = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (we_on_draw) begin
        run++;
        if (run > run_max) run_max = run;
      end else run = 0;
    end
    check("clear_sweep_len", 80'(run_max), 80'(CW));

    tcnt = 30;
    random_run(3000);

    // Reset in the middle of a sweep, then carry on.
    n_tog = !n_tog;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!we_on_draw && waited < 50);
    check("sweep_started", 80'(we_on_draw), 80'(1));
    repeat (10) tick();
    n_rst = 0;
    repeat (3) tick();
    n_rst = 1;
    tcnt = 50;
    random_run(600);

`ifdef LFS_STATS_EN
    force dut.ovr_draw_q  = 16'hFFFF;
    force dut.ovr_clear_q = 16'hFFFF;
    @(posedge clk);
    release dut.ovr_draw_q;
    release dut.ovr_clear_q;
    m_cd = 65535;
    m_cc = 65535;
    random_run(800);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
